// File: rtl/dana_pkg.sv
// Shared types and constants for the DANA two-port RoCC front end.
// Holds the funct encodings, the command/response records and the scratch memory geometry.
package dana_pkg;

  localparam int DATA_W    = 64;
  localparam int ASID_W    = 16;
  localparam int RD_W      = 5;
  localparam int FUNCT_W   = 7;
  localparam int MEM_DEPTH = 16;
  localparam int IDX_W     = $clog2(MEM_DEPTH);

  localparam logic [FUNCT_W-1:0] F_SET_ASID = 7'd0;
  localparam logic [FUNCT_W-1:0] F_WRITE    = 7'd1;
  localparam logic [FUNCT_W-1:0] F_READ     = 7'd2;
  localparam logic [FUNCT_W-1:0] F_STATUS   = 7'd3;

  // Only the command fields the engine acts on; the remaining instruction bits are ignored.
  typedef struct packed {
    logic [FUNCT_W-1:0] funct;
    logic [RD_W-1:0]    rd;
    logic               xd;
    logic               s;
    logic [DATA_W-1:0]  rs1;
    logic [DATA_W-1:0]  rs2;
  } rocc_cmd_t;

  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } rocc_resp_t;

  function automatic logic [DATA_W-1:0] asid_word(input logic [ASID_W-1:0] asid);
    return {{(DATA_W-ASID_W){1'b0}}, asid};
  endfunction

endpackage

// File: rtl/rocc_rr_arbiter.sv
// Two-requester round-robin arbiter; a requester with an undelivered response is held off.
// Handshake: a command transfers on a cycle where valid_i[n] and ready_o[n] are both high.
module rocc_rr_arbiter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] valid_i,
  input  logic [1:0] pend_i,
  output logic [1:0] ready_o,
  output logic [1:0] grant_o
);

  logic rr_q;
  logic rr_d;

  // The pointer favours one core, but an idle partner never blocks the other one.
  always_comb begin
    ready_o[0] = !pend_i[0] && (!rr_q || !valid_i[1]);
    ready_o[1] = !pend_i[1] && ( rr_q || !valid_i[0]);
  end

  assign grant_o = valid_i & ready_o;

  always_comb begin
    rr_d = rr_q;
    if (|grant_o) begin
      rr_d = ~rr_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/dana_top.sv
// DANA RoCC front end: arbitrates two cores into one engine with per-core ASIDs
// and a shared ASID-tagged 16x64 scratch memory; responses return to the issuer.
module dana_top (
  input  logic        clk,
  input  logic        reset,
  output logic        io_arbiter_0_cmd_ready,
  input  logic        io_arbiter_0_cmd_valid,
  input  logic [6:0]  io_arbiter_0_cmd_bits_inst_funct,
  input  logic [4:0]  io_arbiter_0_cmd_bits_inst_rs2,
  input  logic [4:0]  io_arbiter_0_cmd_bits_inst_rs1,
  input  logic        io_arbiter_0_cmd_bits_inst_xd,
  input  logic        io_arbiter_0_cmd_bits_inst_xs1,
  input  logic        io_arbiter_0_cmd_bits_inst_xs2,
  input  logic [4:0]  io_arbiter_0_cmd_bits_inst_rd,
  input  logic [6:0]  io_arbiter_0_cmd_bits_inst_opcode,
  input  logic [63:0] io_arbiter_0_cmd_bits_rs1,
  input  logic [63:0] io_arbiter_0_cmd_bits_rs2,
  input  logic        io_arbiter_0_resp_ready,
  output logic        io_arbiter_0_resp_valid,
  output logic [4:0]  io_arbiter_0_resp_bits_rd,
  output logic [63:0] io_arbiter_0_resp_bits_data,
  output logic        io_arbiter_0_busy,
  input  logic        io_arbiter_0_s,
  output logic        io_arbiter_0_interrupt,
  output logic        io_arbiter_1_cmd_ready,
  input  logic        io_arbiter_1_cmd_valid,
  input  logic [6:0]  io_arbiter_1_cmd_bits_inst_funct,
  input  logic [4:0]  io_arbiter_1_cmd_bits_inst_rs2,
  input  logic [4:0]  io_arbiter_1_cmd_bits_inst_rs1,
  input  logic        io_arbiter_1_cmd_bits_inst_xd,
  input  logic        io_arbiter_1_cmd_bits_inst_xs1,
  input  logic        io_arbiter_1_cmd_bits_inst_xs2,
  input  logic [4:0]  io_arbiter_1_cmd_bits_inst_rd,
  input  logic [6:0]  io_arbiter_1_cmd_bits_inst_opcode,
  input  logic [63:0] io_arbiter_1_cmd_bits_rs1,
  input  logic [63:0] io_arbiter_1_cmd_bits_rs2,
  input  logic        io_arbiter_1_resp_ready,
  output logic        io_arbiter_1_resp_valid,
  output logic [4:0]  io_arbiter_1_resp_bits_rd,
  output logic [63:0] io_arbiter_1_resp_bits_data,
  output logic        io_arbiter_1_busy,
  input  logic        io_arbiter_1_s,
  output logic        io_arbiter_1_interrupt
);

  import dana_pkg::*;

  rocc_cmd_t          cmd0_c;
  rocc_cmd_t          cmd1_c;
  rocc_cmd_t          cmd_c;
  logic [1:0]         ready_c;
  logic [1:0]         grant_c;
  logic [1:0]         resp_ready_c;
  logic               sel_c;
  logic [IDX_W-1:0]   idx_c;
  logic [ASID_W-1:0]  cur_asid_c;

  logic [DATA_W-1:0]  exec_data_d;
  logic               exec_err_d;
  logic               set_asid_d;
  logic               write_d;

  logic [ASID_W-1:0]  asid_q      [2];
  logic [DATA_W-1:0]  mem_q       [MEM_DEPTH];
  logic [ASID_W-1:0]  owner_q     [MEM_DEPTH];
  rocc_resp_t         resp_q      [2];
  logic               resp_valid_q[2];
  logic               irq_q       [2];

  logic               unused_ok;

  assign cmd0_c = '{funct: io_arbiter_0_cmd_bits_inst_funct,
                    rd:    io_arbiter_0_cmd_bits_inst_rd,
                    xd:    io_arbiter_0_cmd_bits_inst_xd,
                    s:     io_arbiter_0_s,
                    rs1:   io_arbiter_0_cmd_bits_rs1,
                    rs2:   io_arbiter_0_cmd_bits_rs2};

  assign cmd1_c = '{funct: io_arbiter_1_cmd_bits_inst_funct,
                    rd:    io_arbiter_1_cmd_bits_inst_rd,
                    xd:    io_arbiter_1_cmd_bits_inst_xd,
                    s:     io_arbiter_1_s,
                    rs1:   io_arbiter_1_cmd_bits_rs1,
                    rs2:   io_arbiter_1_cmd_bits_rs2};

  assign resp_ready_c = {io_arbiter_1_resp_ready, io_arbiter_0_resp_ready};

  rocc_rr_arbiter u_arb (
    .clk_i   (clk),
    .rst_i   (reset),
    .valid_i ({io_arbiter_1_cmd_valid, io_arbiter_0_cmd_valid}),
    .pend_i  ({resp_valid_q[1], resp_valid_q[0]}),
    .ready_o (ready_c),
    .grant_o (grant_c)
  );

  // Grants are one-hot, so the engine only needs to know whether core 1 won.
  assign sel_c      = grant_c[1];
  assign cmd_c      = sel_c ? cmd1_c : cmd0_c;
  assign idx_c      = cmd_c.rs1[IDX_W-1:0];
  assign cur_asid_c = asid_q[sel_c];

  always_comb begin
    exec_data_d = '0;
    exec_err_d  = 1'b0;
    set_asid_d  = 1'b0;
    write_d     = 1'b0;
    case (cmd_c.funct)
      F_SET_ASID: begin
        if (cmd_c.s) begin
          set_asid_d = 1'b1;
        end else begin
          exec_err_d = 1'b1;
        end
      end
      F_WRITE: write_d = 1'b1;
      F_READ: begin
        if (owner_q[idx_c] == cur_asid_c) begin
          exec_data_d = mem_q[idx_c];
        end else begin
          exec_err_d = 1'b1;
        end
      end
      F_STATUS: exec_data_d = asid_word(cur_asid_c);
      default:  exec_err_d  = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i]   <= '0;
        owner_q[i] <= '0;
      end
      for (int n = 0; n < 2; n++) begin
        asid_q[n]       <= '0;
        resp_q[n]       <= '0;
        resp_valid_q[n] <= 1'b0;
        irq_q[n]        <= 1'b0;
      end
    end else begin
      if (|grant_c) begin
        if (set_asid_d) begin
          asid_q[sel_c] <= cmd_c.rs1[ASID_W-1:0];
        end
        if (write_d) begin
          mem_q[idx_c]   <= cmd_c.rs2;
          owner_q[idx_c] <= cur_asid_c;
        end
      end
      // A core is only granted while its response slot is empty, so load and drain never collide.
      for (int n = 0; n < 2; n++) begin
        if (grant_c[n]) begin
          irq_q[n] <= exec_err_d;
          if (cmd_c.xd) begin
            resp_valid_q[n] <= 1'b1;
            resp_q[n]       <= '{rd: cmd_c.rd, data: exec_data_d};
          end
        end else if (resp_valid_q[n] && resp_ready_c[n]) begin
          resp_valid_q[n] <= 1'b0;
        end
      end
    end
  end

  assign io_arbiter_0_cmd_ready      = ready_c[0];
  assign io_arbiter_0_resp_valid     = resp_valid_q[0];
  assign io_arbiter_0_resp_bits_rd   = resp_q[0].rd;
  assign io_arbiter_0_resp_bits_data = resp_q[0].data;
  assign io_arbiter_0_busy           = resp_valid_q[0];
  assign io_arbiter_0_interrupt      = irq_q[0];

  assign io_arbiter_1_cmd_ready      = ready_c[1];
  assign io_arbiter_1_resp_valid     = resp_valid_q[1];
  assign io_arbiter_1_resp_bits_rd   = resp_q[1].rd;
  assign io_arbiter_1_resp_bits_data = resp_q[1].data;
  assign io_arbiter_1_busy           = resp_valid_q[1];
  assign io_arbiter_1_interrupt      = irq_q[1];

  // Instruction fields the engine has no use for.
  assign unused_ok = ^{cmd_c.rs1[DATA_W-1:ASID_W],
                       io_arbiter_0_cmd_bits_inst_rs2, io_arbiter_0_cmd_bits_inst_rs1,
                       io_arbiter_0_cmd_bits_inst_xs1, io_arbiter_0_cmd_bits_inst_xs2,
                       io_arbiter_0_cmd_bits_inst_opcode,
                       io_arbiter_1_cmd_bits_inst_rs2, io_arbiter_1_cmd_bits_inst_rs1,
                       io_arbiter_1_cmd_bits_inst_xs1, io_arbiter_1_cmd_bits_inst_xs2,
                       io_arbiter_1_cmd_bits_inst_opcode};

endmodule

// File: tb/tb_dana_top.sv
// Self-checking bench for dana_top: per-core drivers, a reference model that
// predicts every response into a per-core expected queue, and scenario tasks.
module tb_dana_top;

  logic clk;
  logic reset;

  logic        cmd_valid [2];
  logic [6:0]  cmd_funct [2];
  logic [4:0]  cmd_rd    [2];
  logic        cmd_xd    [2];
  logic        cmd_s     [2];
  logic [63:0] cmd_rs1   [2];
  logic [63:0] cmd_rs2   [2];
  logic        resp_ready[2];
  logic [4:0]  ign_rs1f  [2];
  logic [4:0]  ign_rs2f  [2];
  logic        ign_xs1   [2];
  logic        ign_xs2   [2];
  logic [6:0]  ign_opc   [2];

  logic        cmd_ready [2];
  logic        resp_valid[2];
  logic [4:0]  resp_rd   [2];
  logic [63:0] resp_data [2];
  logic        busy      [2];
  logic        irq       [2];

  logic [68:0] exp_q0[$];
  logic [68:0] exp_q1[$];
  int          grant_log[$];

  logic [15:0] m_asid [2];
  logic [63:0] m_mem  [16];
  logic [15:0] m_owner[16];

  int checks;
  int errors;

  dana_top dut (
    .clk                               (clk),
    .reset                             (reset),
    .io_arbiter_0_cmd_ready            (cmd_ready[0]),
    .io_arbiter_0_cmd_valid            (cmd_valid[0]),
    .io_arbiter_0_cmd_bits_inst_funct  (cmd_funct[0]),
    .io_arbiter_0_cmd_bits_inst_rs2    (ign_rs2f[0]),
    .io_arbiter_0_cmd_bits_inst_rs1    (ign_rs1f[0]),
    .io_arbiter_0_cmd_bits_inst_xd     (cmd_xd[0]),
    .io_arbiter_0_cmd_bits_inst_xs1    (ign_xs1[0]),
    .io_arbiter_0_cmd_bits_inst_xs2    (ign_xs2[0]),
    .io_arbiter_0_cmd_bits_inst_rd     (cmd_rd[0]),
    .io_arbiter_0_cmd_bits_inst_opcode (ign_opc[0]),
    .io_arbiter_0_cmd_bits_rs1         (cmd_rs1[0]),
    .io_arbiter_0_cmd_bits_rs2         (cmd_rs2[0]),
    .io_arbiter_0_resp_ready           (resp_ready[0]),
    .io_arbiter_0_resp_valid           (resp_valid[0]),
    .io_arbiter_0_resp_bits_rd         (resp_rd[0]),
    .io_arbiter_0_resp_bits_data       (resp_data[0]),
    .io_arbiter_0_busy                 (busy[0]),
    .io_arbiter_0_s                    (cmd_s[0]),
    .io_arbiter_0_interrupt            (irq[0]),
    .io_arbiter_1_cmd_ready            (cmd_ready[1]),
    .io_arbiter_1_cmd_valid            (cmd_valid[1]),
    .io_arbiter_1_cmd_bits_inst_funct  (cmd_funct[1]),
    .io_arbiter_1_cmd_bits_inst_rs2    (ign_rs2f[1]),
    .io_arbiter_1_cmd_bits_inst_rs1    (ign_rs1f[1]),
    .io_arbiter_1_cmd_bits_inst_xd     (cmd_xd[1]),
    .io_arbiter_1_cmd_bits_inst_xs1    (ign_xs1[1]),
    .io_arbiter_1_cmd_bits_inst_xs2    (ign_xs2[1]),
    .io_arbiter_1_cmd_bits_inst_rd     (cmd_rd[1]),
    .io_arbiter_1_cmd_bits_inst_opcode (ign_opc[1]),
    .io_arbiter_1_cmd_bits_rs1         (cmd_rs1[1]),
    .io_arbiter_1_cmd_bits_rs2         (cmd_rs2[1]),
    .io_arbiter_1_resp_ready           (resp_ready[1]),
    .io_arbiter_1_resp_valid           (resp_valid[1]),
    .io_arbiter_1_resp_bits_rd         (resp_rd[1]),
    .io_arbiter_1_resp_bits_data       (resp_data[1]),
    .io_arbiter_1_busy                 (busy[1]),
    .io_arbiter_1_s                    (cmd_s[1]),
    .io_arbiter_1_interrupt            (irq[1])
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_mem[i]   = '0;
      m_owner[i] = '0;
    end
    m_asid[0] = '0;
    m_asid[1] = '0;
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic model_accept(input int n);
    logic [3:0]  idx;
    logic [63:0] d;
    idx = cmd_rs1[n][3:0];
    d   = '0;
    case (cmd_funct[n])
      7'd0: if (cmd_s[n]) m_asid[n] = cmd_rs1[n][15:0];
      7'd1: begin
        m_mem[idx]   = cmd_rs2[n];
        m_owner[idx] = m_asid[n];
      end
      7'd2: if (m_owner[idx] == m_asid[n]) d = m_mem[idx];
      7'd3: d = {48'b0, m_asid[n]};
      default: d = '0;
    endcase
    if (cmd_xd[n]) begin
      if (n == 0) exp_q0.push_back({cmd_rd[n], d});
      else        exp_q1.push_back({cmd_rd[n], d});
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      for (int n = 0; n < 2; n++) begin
        if (resp_valid[n] && resp_ready[n]) begin
          logic [68:0] exp;
          logic        have;
          have = (n == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
          checks++;
          if (!have) begin
            errors++;
            $display("FAIL resp_unexpected core %0d: got rd=%0d data=%h, required no response", n, resp_rd[n], resp_data[n]);
          end else begin
            exp = (n == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            if ({resp_rd[n], resp_data[n]} !== exp) begin
              errors++;
              $display("FAIL resp_data core %0d: got rd=%0d data=%h, required rd=%0d data=%h",
                       n, resp_rd[n], resp_data[n], exp[68:64], exp[63:0]);
            end
          end
        end
        if (cmd_valid[n] && cmd_ready[n]) begin
          model_accept(n);
          grant_log.push_back(n);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic apply_reset();
    cmd_valid[0] = 1'b0;
    cmd_valid[1] = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int n, input logic [6:0] f, input logic [63:0] a,
                       input logic [63:0] b, input logic x, input logic [4:0] rd,
                       input logic sv);
    int waited;
    cmd_funct[n] = f;
    cmd_rs1[n]   = a;
    cmd_rs2[n]   = b;
    cmd_xd[n]    = x;
    cmd_rd[n]    = rd;
    cmd_s[n]     = sv;
    cmd_valid[n] = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!cmd_ready[n] && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!cmd_ready[n]) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout core %0d: cmd_ready=0 after %0d cycles, required 1", n, waited);
    end else begin
      @(posedge clk);
      #1;
    end
    cmd_valid[n] = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    for (int n = 0; n < 2; n++) begin
      checks++;
      if (resp_valid[n] !== 1'b0 || busy[n] !== 1'b0 || irq[n] !== 1'b0) begin
        errors++;
        $display("FAIL reset_flags core %0d: got valid=%b busy=%b irq=%b, required 0 0 0", n, resp_valid[n], busy[n], irq[n]);
      end
      checks++;
      if (resp_rd[n] !== 5'd0 || resp_data[n] !== 64'd0) begin
        errors++;
        $display("FAIL reset_resp core %0d: got rd=%0d data=%h, required 0 0", n, resp_rd[n], resp_data[n]);
      end
      checks++;
      if (cmd_ready[n] !== 1'b1) begin
        errors++;
        $display("FAIL reset_ready core %0d: got %b, required 1", n, cmd_ready[n]);
      end
    end
  endtask

  task automatic test_set_asid();
    issue(0, 7'd0, 64'h5, 64'h0, 1'b1, 5'd3, 1'b1);
    checks++;
    if (resp_valid[0] !== 1'b1 || resp_rd[0] !== 5'd3 || resp_data[0] !== 64'd0) begin
      errors++;
      $display("FAIL set_asid_resp: got valid=%b rd=%0d data=%h, required 1 3 0", resp_valid[0], resp_rd[0], resp_data[0]);
    end
    issue(0, 7'd3, 64'h0, 64'h0, 1'b1, 5'd4, 1'b1);
    checks++;
    if (resp_data[0] !== 64'h5) begin
      errors++;
      $display("FAIL status_after_set: got %h, required 5", resp_data[0]);
    end
  endtask

  task automatic test_write_read();
    // No response on the write, so the read lands on the very next edge.
    issue(0, 7'd1, 64'h2, 64'hDEADBEEF, 1'b0, 5'd0, 1'b1);
    checks++;
    if (resp_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL write_xd0_resp: got valid=%b, required 0", resp_valid[0]);
    end
    issue(0, 7'd2, 64'h2, 64'h0, 1'b1, 5'd7, 1'b1);
    checks++;
    if (resp_data[0] !== 64'hDEADBEEF || irq[0] !== 1'b0) begin
      errors++;
      $display("FAIL read_own: got data=%h irq=%b, required deadbeef 0", resp_data[0], irq[0]);
    end
  endtask

  task automatic test_asid_mismatch();
    issue(1, 7'd0, 64'h7, 64'h0, 1'b1, 5'd1, 1'b1);
    issue(1, 7'd2, 64'h2, 64'h0, 1'b1, 5'd2, 1'b1);
    checks++;
    if (resp_data[1] !== 64'd0 || irq[1] !== 1'b1) begin
      errors++;
      $display("FAIL read_foreign: got data=%h irq=%b, required 0 1", resp_data[1], irq[1]);
    end
    issue(1, 7'd3, 64'h0, 64'h0, 1'b1, 5'd9, 1'b1);
    checks++;
    if (resp_data[1] !== 64'h7 || irq[1] !== 1'b0) begin
      errors++;
      $display("FAIL irq_clear: got data=%h irq=%b, required 7 0", resp_data[1], irq[1]);
    end
  endtask

  task automatic test_errors();
    issue(0, 7'd0, 64'h99, 64'h0, 1'b1, 5'd5, 1'b0);
    checks++;
    if (irq[0] !== 1'b1 || resp_data[0] !== 64'd0) begin
      errors++;
      $display("FAIL set_asid_user: got irq=%b data=%h, required 1 0", irq[0], resp_data[0]);
    end
    issue(0, 7'd3, 64'h0, 64'h0, 1'b1, 5'd6, 1'b1);
    checks++;
    if (resp_data[0] !== 64'h5 || irq[0] !== 1'b0) begin
      errors++;
      $display("FAIL asid_unchanged: got data=%h irq=%b, required 5 0", resp_data[0], irq[0]);
    end
    issue(0, 7'd9, 64'h0, 64'h0, 1'b0, 5'd0, 1'b1);
    checks++;
    if (irq[0] !== 1'b1 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL bad_funct: got irq=%b busy=%b, required 1 0", irq[0], busy[0]);
    end
  endtask

  task automatic test_random_rw();
    for (int i = 0; i < 6; i++) begin
      logic [63:0] idx;
      logic [63:0] val;
      idx = 64'($urandom_range(0, 15));
      val = {$urandom, $urandom};
      issue(0, 7'd1, idx, val, 1'b0, 5'd0, 1'b1);
      issue(0, 7'd2, idx, 64'h0, 1'b1, 5'($urandom_range(0, 31)), 1'b1);
      issue(1, 7'd2, idx, 64'h0, 1'b1, 5'($urandom_range(0, 31)), 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    grant_log.delete();
    for (int n = 0; n < 2; n++) begin
      cmd_funct[n]  = 7'd3;
      cmd_xd[n]     = 1'b1;
      cmd_rd[n]     = 5'(n + 1);
      cmd_s[n]      = 1'b1;
      resp_ready[n] = 1'b1;
    end
    cmd_valid[0] = 1'b1;
    cmd_valid[1] = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    cmd_valid[0] = 1'b0;
    cmd_valid[1] = 1'b0;
    checks++;
    if (grant_log.size() != 8) begin
      errors++;
      $display("FAIL rr_grant_count: got %0d, required 8", grant_log.size());
    end
    for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
      checks++;
      if (grant_log[i] != (i % 2)) begin
        errors++;
        $display("FAIL rr_order[%0d]: got core %0d, required core %0d", i, grant_log[i], i % 2);
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    resp_ready[0] = 1'b0;
    issue(0, 7'd3, 64'h0, 64'h0, 1'b1, 5'd4, 1'b1);
    checks++;
    if (busy[0] !== 1'b1 || cmd_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL held_busy: got busy=%b ready=%b, required 1 0", busy[0], cmd_ready[0]);
    end
    for (int i = 0; i < 3; i++) begin
      issue(1, 7'd1, 64'(8 + i), {$urandom, $urandom}, 1'b1, 5'(i), 1'b1);
    end
    checks++;
    if (busy[0] !== 1'b1 || resp_valid[0] !== 1'b1) begin
      errors++;
      $display("FAIL still_held: got busy=%b valid=%b, required 1 1", busy[0], resp_valid[0]);
    end
    resp_ready[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL ready_in_handshake: got %b, required 0", cmd_ready[0]);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_handshake: got ready=%b busy=%b, required 1 0", cmd_ready[0], busy[0]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    resp_ready[0] = 1'b0;
    issue(0, 7'd9, 64'h0, 64'h0, 1'b1, 5'd2, 1'b1);
    checks++;
    if (resp_valid[0] !== 1'b1 || irq[0] !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got valid=%b irq=%b, required 1 1", resp_valid[0], irq[0]);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (resp_valid[0] !== 1'b0 || irq[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got valid=%b irq=%b busy=%b, required 0 0 0", resp_valid[0], irq[0], busy[0]);
    end
    apply_reset();
    resp_ready[0] = 1'b1;
    issue(0, 7'd3, 64'h0, 64'h0, 1'b1, 5'd1, 1'b1);
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    for (int n = 0; n < 2; n++) begin
      cmd_valid[n]  = 1'b0;
      cmd_funct[n]  = '0;
      cmd_rd[n]     = '0;
      cmd_xd[n]     = 1'b0;
      cmd_s[n]      = 1'b0;
      cmd_rs1[n]    = '0;
      cmd_rs2[n]    = '0;
      resp_ready[n] = 1'b1;
      ign_rs1f[n]   = 5'($urandom_range(0, 31));
      ign_rs2f[n]   = 5'($urandom_range(0, 31));
      ign_xs1[n]    = 1'($urandom_range(0, 1));
      ign_xs2[n]    = 1'($urandom_range(0, 1));
      ign_opc[n]    = 7'h0b;
    end
    model_clear();

    test_reset();
    test_set_asid();
    test_write_read();
    test_asid_mismatch();
    test_errors();
    test_random_rw();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();

    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d responses outstanding, required 0/0", exp_q0.size(), exp_q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
